// File: rtl/adc_2308_model.sv
// Responder-side model of an LTC2308 SPI ADC, fully in the clk domain via oversampled inputs.
// Optional sleep mode enabled by defining ADC_2308_MODEL_SLEEP_EN.
module adc_2308_model #(
    parameter int         CONV_CYCLES = 80,
    parameter int         CNTW        = 8,
    parameter logic [5:0] DEFAULT_CFG = 6'b100010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_convst,
    input  logic        adc_sck,
    input  logic        adc_sdi,
    output logic        adc_sdo,
    input  logic [95:0] ch_data,
    output logic        busy,
    output logic        frame_done,
    output logic [5:0]  cfg,
    output logic        asleep
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CONV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2
`ifdef ADC_2308_MODEL_SLEEP_EN
        , SLEEP = 2'd3
`endif
    } state_t;

    // UNI=0 maps the straight-binary sample to two's complement by flipping the MSB
    function automatic logic [11:0] code_sample(input logic [11:0] s, input logic uni);
        return uni ? s : (s ^ 12'h800);
    endfunction

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [3:0]        bit_cnt;
    logic [5:0]        sr;
    logic [11:0]       result;
    logic              sdo_clr;

    logic convst_s1, convst_s2, convst_d;
    logic sck_s1, sck_s2, sck_d;
    logic sdi_s1, sdi_s2;

    logic        convst_rise, sck_rise, sck_fall, start;
    logic [2:0]  ch_sel;
    logic [11:0] sel_sample;

    assign convst_rise = convst_s2 & ~convst_d;
    assign sck_rise    = sck_s2 & ~sck_d;
    assign sck_fall    = ~sck_s2 & sck_d;
    assign start       = convst_rise && (state == IDLE || state == SHIFT);
    assign ch_sel      = {cfg[3], cfg[2], cfg[4]};

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < 8; i++) begin
            if (ch_sel == 3'(i)) sel_sample = ch_data[12*i +: 12];
        end
    end

`ifndef ADC_2308_MODEL_SLEEP_EN
    assign asleep = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            convst_s1  <= 1'b0;
            convst_s2  <= 1'b0;
            convst_d   <= 1'b0;
            sck_s1     <= 1'b0;
            sck_s2     <= 1'b0;
            sck_d      <= 1'b0;
            sdi_s1     <= 1'b0;
            sdi_s2     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            result     <= '0;
            sdo_clr    <= 1'b0;
            adc_sdo    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg        <= DEFAULT_CFG;
`ifdef ADC_2308_MODEL_SLEEP_EN
            asleep     <= 1'b0;
`endif
        end else begin
            convst_s1  <= adc_convst;
            convst_s2  <= convst_s1;
            convst_d   <= convst_s2;
            sck_s1     <= adc_sck;
            sck_s2     <= sck_s1;
            sck_d      <= sck_s2;
            sdi_s1     <= adc_sdi;
            sdi_s2     <= sdi_s1;
            frame_done <= 1'b0;

            // A CONVST edge wins over any SCK edge in the same clk and aborts a partial frame
            if (start) begin
                result  <= code_sample(sel_sample, cfg[1]);
                cnt     <= '0;
                busy    <= 1'b1;
                sdo_clr <= 1'b0;
                state   <= CONV;
            end else begin
                case (state)
                    IDLE: begin
                        if (sck_fall && sdo_clr) begin
                            adc_sdo <= 1'b0;
                            sdo_clr <= 1'b0;
                        end
                    end
                    CONV: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            busy    <= 1'b0;
                            adc_sdo <= result[11];
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            if (bit_cnt < 4'd6) sr <= {sr[4:0], sdi_s2};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd11) begin
                                cfg        <= sr;
                                frame_done <= 1'b1;
`ifdef ADC_2308_MODEL_SLEEP_EN
                                if (sr[0]) begin
                                    asleep  <= 1'b1;
                                    adc_sdo <= 1'b0;
                                    state   <= SLEEP;
                                end else begin
                                    sdo_clr <= 1'b1;
                                    state   <= IDLE;
                                end
`else
                                sdo_clr <= 1'b1;
                                state   <= IDLE;
`endif
                            end
                        end else if (sck_fall) begin
                            result  <= {result[10:0], 1'b0};
                            adc_sdo <= result[10];
                        end
                    end
`ifdef ADC_2308_MODEL_SLEEP_EN
                    SLEEP: begin
                        // The waking CONVST edge is consumed without converting
                        if (convst_rise) begin
                            asleep <= 1'b0;
                            state  <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_2308_model.sv
// Scoreboard bench for adc_2308_model: SPI master stimulus, queue of expected frames, decoupled monitor.
module tb_adc_2308_model;

    localparam logic [5:0] DEF_CFG = 6'b100010;

    typedef struct {
        logic [11:0] data;
        logic [5:0]  cfg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [95:0] ch_data;
    logic        busy;
    logic        frame_done;
    logic [5:0]  cfg;
    logic        asleep;

    logic [11:0] chan [8];
    assign ch_data = {chan[7], chan[6], chan[5], chan[4], chan[3], chan[2], chan[1], chan[0]};

    adc_2308_model dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_convst (adc_convst),
        .adc_sck    (adc_sck),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo),
        .ch_data    (ch_data),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg        (cfg),
        .asleep     (asleep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          fd_count = 0;
    int          frames_issued = 0;
    exp_t        exp_q [$];
    logic [5:0]  model_cfg = DEF_CFG;
    logic [11:0] pend_data = '0;
    logic [11:0] cap = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: channel index from the S1,S0,O/S bits; bipolar is the sample offset by half scale
    function automatic logic [11:0] ref_sample(input logic [5:0] c);
        int sel;
        int v;
        sel = (c[3] ? 4 : 0) + (c[2] ? 2 : 0) + (c[4] ? 1 : 0);
        v = int'(chan[sel]);
        if (!c[1]) v = (v + 2048) % 4096;
        return 12'(v);
    endfunction

    always @(posedge adc_sck) cap <= {cap[10:0], adc_sdo};

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            exp_t e;
            fd_count++;
            if (exp_q.size() == 0) begin
                check("frame_done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_data", {20'd0, cap}, {20'd0, e.data});
                check("frame_cfg", {26'd0, cfg}, {26'd0, e.cfg});
            end
        end
    end

    task automatic pulse_convst();
        @(negedge clk) adc_convst = 1'b1;
        repeat (2) @(negedge clk);
        adc_convst = 1'b0;
    endtask

    task automatic start_conv(input bit repulse);
        int n;
        int cnt;
        pend_data = ref_sample(model_cfg);
        pulse_convst();
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise", {31'd0, busy}, 1);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (repulse) adc_convst = (cnt >= 38 && cnt < 41);
        end
        adc_convst = 1'b0;
        check("busy_len", cnt, 80);
    endtask

    task automatic frame(input logic [5:0] sdi_word, input int n_rises);
        if (n_rises == 12) begin
            exp_q.push_back('{data: pend_data, cfg: sdi_word});
            frames_issued++;
        end
        for (int i = 0; i < n_rises; i++) begin
            @(negedge clk) adc_sdi = (i < 6) ? sdi_word[5-i] : 1'b0;
            repeat (3) @(negedge clk);
            adc_sck = 1'b1;
            repeat (4) @(negedge clk);
            adc_sck = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (n_rises == 12) model_cfg = sdi_word;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int fd_before;
        int busy_seen;
        logic [5:0] w;

        rst_n = 1'b0;
        adc_convst = 1'b0;
        adc_sck = 1'b0;
        adc_sdi = 1'b0;
        for (int i = 0; i < 8; i++) chan[i] = 12'($urandom);

        repeat (3) @(negedge clk);
        check("rst_cfg", {26'd0, cfg}, {26'd0, DEF_CFG});
        check("rst_sdo", {31'd0, adc_sdo}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_asleep", {31'd0, asleep}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Default config, CH0 unipolar
        chan[0] = 12'hA5C;
        start_conv(0);
        frame(DEF_CFG, 12);

        // Select CH5 unipolar, then read it back
        chan[5] = 12'h3F1;
        start_conv(0);
        frame(6'b111010, 12);
        check("cfg_ch5", {26'd0, cfg}, {26'd0, 6'b111010});
        start_conv(0);
        frame(6'b111010, 12);

        // Bipolar coding at both ends of the range
        start_conv(0);
        frame(6'b100000, 12);
        chan[0] = 12'h000;
        start_conv(0);
        frame(6'b100000, 12);
        chan[0] = 12'hFFF;
        start_conv(0);
        frame(6'b100000, 12);

        // CONVST during conversion is ignored
        start_conv(1);
        frame(DEF_CFG, 12);

        // Abort after 5 rising SCK edges
        start_conv(0);
        frame(6'b111010, 5);
        fd_before = fd_count;
        start_conv(0);
        check("abort_no_frame_done", fd_count, fd_before);
        check("abort_cfg_kept", {26'd0, cfg}, {26'd0, model_cfg});
        frame(model_cfg, 12);

        // Sleep request
        start_conv(0);
        frame(6'b100011, 12);
`ifdef ADC_2308_MODEL_SLEEP_EN
        check("sleep_asleep", {31'd0, asleep}, 1);
        check("sleep_sdo", {31'd0, adc_sdo}, 0);
        pulse_convst();
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("wake_no_busy", busy_seen, 0);
        check("wake_asleep", {31'd0, asleep}, 0);
`else
        check("sleep_ignored", {31'd0, asleep}, 0);
        busy_seen = 0;
`endif
        start_conv(0);
        frame(DEF_CFG, 12);

        // Randomized frames; channel data changes after the CONVST edge must not matter
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 8; i++) chan[i] = 12'($urandom);
            start_conv(0);
            for (int i = 0; i < 8; i++) chan[i] = 12'($urandom);
            w = 6'($urandom_range(0, 63));
`ifdef ADC_2308_MODEL_SLEEP_EN
            w[0] = 1'b0;
`endif
            frame(w, 12);
        end

        // Asynchronous reset in the middle of a conversion
        pulse_convst();
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_cfg", {26'd0, cfg}, {26'd0, DEF_CFG});
        check("midrst_sdo", {31'd0, adc_sdo}, 0);
        model_cfg = DEF_CFG;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_conv(0);
        frame(6'b110110, 12);

        repeat (10) @(negedge clk);
        check("frame_count", fd_count, frames_issued);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_2308_model.md
Name: adc_2308_model

Overview:
- Synthesizable responder-side model of an LTC2308 8-channel 12-bit SPI ADC.
- Answers CONVST/SCK/SDI from the jtframe_2308 controller and drives SDO.
- Conversion data comes from eight parallel 12-bit sample inputs.
- Used for closed-loop simulation and for board bring-up without a physical ADC; everything runs in the system clock domain via input oversampling.

Parameters:
CONV_CYCLES, 80, clk cycles from CONVST rising edge to result ready (1.6 us at 50 MHz)
CNTW, 8, conversion counter width; must satisfy 2**CNTW > CONV_CYCLES
DEFAULT_CFG, 6'b100010, config word after reset: single-ended, CH0, unipolar, no sleep

Ports:
clk  in  1  system clock; must be at least 8x SCK frequency
rst_n  in  1  asynchronous active-low reset
adc_convst  in  1  conversion start from controller
adc_sck  in  1  serial clock from controller
adc_sdi  in  1  config bits from controller, MSB first
adc_sdo  out  1  result bits to controller, MSB first
ch_data  in  96  channel samples; CHn at [12n+11:12n]
busy  out  1  high while converting
frame_done  out  1  one-clk pulse when a complete 12-bit frame ends
cfg  out  6  active config word {S/D,O/S,S1,S0,UNI,SLP}
asleep  out  1  high while in sleep

Behaviour:
- Reset values: adc_sdo=0, busy=0, frame_done=0, cfg=DEFAULT_CFG, asleep=0, result=0, bit counter=0, state IDLE.
- Input sampling:
  - adc_convst, adc_sck and adc_sdi each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised copy against its previous value.
- Channel select: ch = {S1,S0,O/S}. S/D=0 (differential) converts the positive input of that channel pair, i.e. the same ch.
- Coding: UNI=1 gives straight binary. UNI=0 gives the sample XOR 12'h800 (two's complement).
- States: IDLE, CONV, SHIFT, SLEEP.
- IDLE:
  - CONVST rising edge: latch coded sample of the channel selected by the current cfg into result; counter=0; busy=1; go to CONV.
  - SCK edges are ignored.
- CONV:
  - Counter increments every clk.
  - When counter reaches CONV_CYCLES-1: busy=0; adc_sdo=result[11]; bit counter=0; go to SHIFT.
  - CONVST edges and SCK edges are ignored in CONV.
- SHIFT:
  - SCK rising edge: SDI is shifted into a 6-bit config shift register while bit counter<6; bit counter increments.
  - SCK falling edge: result shifts left by one; adc_sdo takes the new result[11] on the next clk.
  - On the 12th rising edge: cfg loads the shift register; frame_done pulses for 1 clk; adc_sdo=0 on the following falling edge; go to IDLE.
  - SDO-to-SCK-fall latency is 3 clk (2 synchroniser stages, 1 edge register).
- Abort: a CONVST rising edge in SHIFT before the 12th rising SCK edge discards the partial frame.
  - cfg is unchanged and frame_done does not pulse.
  - A new conversion starts exactly as from IDLE.
- Simultaneous events: a CONVST rising edge in the same clk as an SCK edge takes priority and the SCK edge is dropped.
- Sample timing: ch_data is sampled only on the CONVST edge. Later changes do not affect the frame in progress.
- Reset mid-operation returns to the reset values immediately (asynchronous). The next CONVST starts cleanly.

Optional Feature:
- Macro: ADC_2308_MODEL_SLEEP_EN.
- Defined:
  - A completed frame with the new cfg[0]=1 enters SLEEP; asleep=1 and adc_sdo=0.
  - In SLEEP, the first CONVST rising edge only wakes the model (asleep=0, go to IDLE) and does not convert.
  - The next CONVST edge converts normally.
- Undefined:
  - SLP is stored in cfg but ignored.
  - asleep is tied to 0 and the SLEEP state does not exist.

Test Plan:
- Reset with rst_n low for 3 clk -> cfg=6'b100010, adc_sdo=0, busy=0, asleep=0.
- ch0=12'hA5C, CONVST pulse, wait 80 clk, 12 SCK cycles at clk/8 -> busy high exactly 80 clk; SDO reads 1010_0101_1100; frame_done pulses once.
- Frame with SDI=6'b111010 (CH5, unipolar), ch5=12'h3F1; next conversion plus frame -> cfg=6'b111010; second frame returns 12'h3F1.
- cfg UNI=0 with ch0=12'h000 -> frame returns 12'h800; ch0=12'hFFF -> returns 12'h7FF.
- CONVST re-pulsed at clk 40 of CONV -> ignored, busy still drops at clk 80. CONVST pulsed after 5 SCK rising edges of a frame carrying SDI=6'b111010 -> no frame_done, cfg unchanged, busy high again.
- With ADC_2308_MODEL_SLEEP_EN defined:
  - SDI=6'b100011 -> asleep=1 after the frame.
  - Next CONVST -> asleep=0, busy stays 0.
  - Following CONVST -> normal conversion.
